muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the RV32M/RV64M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) in the RISC-V execute stage. It sits beside the ALU and is selected by the decoder when the opcode is OP with funct7 = 0000001. Operands are captured on a start pulse, and the unit computes over roughly XLEN cycles. It returns the result with a one-cycle done pulse, and the pipeline stalls on busy.

---
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with the sign applied on the final write. Divide-by-zero and signed
// overflow complete immediately without iterating.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Shared datapath registers.
    //   multiply: r_opnd = |a|, r_lo = |b| shifting out / product low half
    //             shifting in, r_hi = product high half
    //   divide:   r_opnd = |b|, r_lo = |a| shifting out / quotient shifting
    //             in, r_hi = partial remainder
    logic [2:0]      r_func3;
    logic            r_neg;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_lo;
    logic [XLEN:0]   r_hi;
    logic [XLEN-1:0] r_result;

    // Acceptance-time decode
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_neg;
    logic            w_div0;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic            w_accept;

    // Iteration datapath
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN+1:0]   w_div_diff;
    logic              w_div_ok;

    // Final sign correction
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_div_res;
    logic [XLEN-1:0]   w_div_s;
    logic [XLEN-1:0]   w_final;

    // Operand decode: signedness, magnitudes, result sign and fast paths
    always_comb begin
        w_is_div   = func3[2];
        // MULH(001), MULHSU(010), DIV(100), REM(110) sign-interpret op_a
        w_a_signed = (func3 == 3'b001) || (func3 == 3'b010) ||
                     (func3 == 3'b100) || (func3 == 3'b110);
        // MULHSU leaves op_b unsigned
        w_b_signed = (func3 == 3'b001) || (func3 == 3'b100) ||
                     (func3 == 3'b110);
        w_a_sgn    = w_a_signed & op_a[XLEN-1];
        w_b_sgn    = w_b_signed & op_b[XLEN-1];
        // Negating the most negative value yields 2^(XLEN-1), its exact magnitude
        w_a_mag    = w_a_sgn ? (~op_a + 1'b1) : op_a;
        w_b_mag    = w_b_sgn ? (~op_b + 1'b1) : op_b;
        // Remainder takes the dividend's sign; everything else the XOR
        w_neg      = (w_is_div && func3[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
        w_div0     = w_is_div && (op_b == '0);
        w_ovf      = w_is_div && !func3[0] && (op_a == MIN_NEG) && (op_b == '1);
        w_fast     = w_div0 || w_ovf;
        w_fast_res = '0;
        if (w_div0)
            w_fast_res = func3[1] ? op_a : '1;
        else if (w_ovf)
            w_fast_res = func3[1] ? '0 : op_a;
        // kill beats start; start is ignored while iterating
        w_accept   = start && !kill && (r_state != S_CALC);
    end

    // One iteration step for each operation, plus the sign-corrected result
    always_comb begin
        w_mul_sum  = r_hi + {1'b0, (r_lo[0] ? r_opnd : {XLEN{1'b0}})};
        w_div_sh   = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
        w_div_diff = {1'b0, w_div_sh} - {2'b00, r_opnd};
        w_div_ok   = !w_div_diff[XLEN+1];

        w_prod     = {r_hi[XLEN-1:0], r_lo};
        w_prod_s   = r_neg ? (~w_prod + 1'b1) : w_prod;
        w_div_res  = r_func3[1] ? r_hi[XLEN-1:0] : r_lo;
        w_div_s    = r_neg ? (~w_div_res + 1'b1) : w_div_res;
        if (r_func3[2])
            w_final = w_div_s;
        else if (r_func3[1:0] == 2'b00)
            w_final = w_prod_s[XLEN-1:0];
        else
            w_final = w_prod_s[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_FIN: begin
                    if (start)
                        w_state_nxt = w_fast ? S_FIN : S_CALC;
                    else
                        w_state_nxt = S_IDLE;
                end
                S_CALC: begin
                    if (r_cnt == CNT_LAST)
                        w_state_nxt = S_FIN;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand capture, iteration and result write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_func3  <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_func3 <= func3;
            r_neg   <= w_neg;
            r_cnt   <= '0;
            r_hi    <= '0;
            if (w_is_div) begin
                r_opnd <= w_b_mag;
                r_lo   <= w_a_mag;
            end else begin
                r_opnd <= w_a_mag;
                r_lo   <= w_b_mag;
            end
            if (w_fast)
                r_result <= w_fast_res;
        end else if ((r_state == S_CALC) && !kill) begin
            if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_func3[2]) begin
                    // Restoring step: keep the difference only if no borrow
                    r_hi <= w_div_ok ? w_div_diff[XLEN:0] : w_div_sh;
                    r_lo <= {r_lo[XLEN-2:0], w_div_ok};
                end else begin
                    // Shift-add step: carry of the add enters the high half
                    r_hi <= {1'b0, w_mul_sum[XLEN:1]};
                    r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                end
            end else begin
                r_result <= w_final;
            end
        end
    end

    // Status decoded from registered state only
    always_comb begin
        busy   = (r_state == S_CALC);
        done   = (r_state == S_FIN);
        result = r_result;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit at XLEN=32 and
// XLEN=8 against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start32, kill32, busy32, done32;
    logic [2:0]  f32;
    logic [31:0] a32, b32, res32;
    logic        start8, kill8, busy8, done8;
    logic [2:0]  f8;
    logic [7:0]  a8, b8, res8;

    int n_tests;
    int n_fail;

    muldiv_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .reset(rst), .start(start32), .kill(kill32), .func3(f32),
        .op_a(a32), .op_b(b32), .busy(busy32), .done(done32), .result(res32)
    );

    muldiv_unit #(.XLEN(8)) u_dut8 (
        .clk(clk), .reset(rst), .start(start8), .kill(kill8), .func3(f8),
        .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .result(res8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic with RISC-V corner rules
    function automatic logic [31:0] ref_model(input int w, input logic [2:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
        longint m, ua, ub, sa, sb, q;
        logic signed [127:0] x, y, pr;
        logic [31:0] mk;
        m  = (longint'(1) << w) - 1;
        mk = 32'(m);
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (ua >= (longint'(1) << (w-1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w-1))) ? ub - (longint'(1) << w) : ub;
        x = (f == 3'd1 || f == 3'd2) ? sa : ua;
        y = (f == 3'd1) ? sb : ub;
        pr = x * y;
        case (f)
            3'd0: return 32'(pr) & mk;
            3'd1, 3'd2, 3'd3: return 32'(pr >>> w) & mk;
            3'd4: begin
                if (ub == 0) return mk;
                q = sa / sb;
                return 32'(q) & mk;
            end
            3'd5: begin
                if (ub == 0) return mk;
                return 32'(ua / ub) & mk;
            end
            3'd6: begin
                if (ub == 0) return 32'(ua);
                q = sa % sb;
                return 32'(q) & mk;
            end
            default: begin
                if (ub == 0) return 32'(ua);
                return 32'(ua % ub) & mk;
            end
        endcase
    endfunction

    // Issue one op; if now_cycle0 the caller is already inside cycle 0.
    // Returns during the done cycle so a back-to-back start can follow.
    task automatic run_op(input int w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit now_cycle0, input string tag,
                          output logic [31:0] res);
        logic [31:0] exp, mk, am, bm, minv;
        bit fast;
        int done_cyc, busy_cnt;
        logic bz, dn;
        mk   = (w == 32) ? 32'hFFFF_FFFF : 32'hFF;
        minv = 32'h1 << (w - 1);
        am   = a & mk;
        bm   = b & mk;
        exp  = ref_model(w, f, a, b);
        fast = f[2] && ((bm == 0) || (!f[0] && am == minv && bm == mk));
        res  = '0;
        if (!now_cycle0) begin
            @(posedge clk); #1;
        end
        if (w == 32) begin start32 = 1; f32 = f; a32 = a; b32 = b; end
        else begin start8 = 1; f8 = f; a8 = a[7:0]; b8 = b[7:0]; end
        @(posedge clk); #1;
        // operands may change freely after acceptance
        start32 = 0; start8 = 0;
        if (w == 32) begin f32 = 3'($urandom); a32 = $urandom; b32 = $urandom; end
        else begin f8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
        done_cyc = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 80 && done_cyc == 0; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            bz = (w == 32) ? busy32 : busy8;
            dn = (w == 32) ? done32 : done8;
            if (bz) busy_cnt++;
            if (dn) begin
                done_cyc = c;
                res = (w == 32) ? res32 : {24'h0, res8};
            end
        end
        chk({tag, "_done_cycle"}, done_cyc, fast ? 1 : w + 2);
        chk({tag, "_busy_cycles"}, busy_cnt, fast ? 0 : w + 1);
        chk({tag, "_result"}, res, exp);
    endtask

    initial begin
        logic [31:0] r, r0, ra, rb, mk;
        logic [2:0] rf;
        int cnt;
        n_tests = 0;
        n_fail  = 0;
        start32 = 0; kill32 = 0; f32 = 0; a32 = 0; b32 = 0;
        start8  = 0; kill8  = 0; f8  = 0; a8  = 0; b8  = 0;
        rst = 1;
        #12;
        chk("reset_busy", busy32, 0);
        chk("reset_done", done32, 0);
        chk("reset_result", res32, 0);
        chk("reset_busy8", busy8, 0);
        rst = 0;

        // Directed XLEN=32 multiplies
        run_op(32, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_ff", r);
        chk("mul_ff_const", r, 32'h0000_0001);
        run_op(32, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_ff", r);
        chk("mulh_ff_const", r, 32'h0000_0000);
        run_op(32, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_ff", r);
        chk("mulhu_ff_const", r, 32'hFFFF_FFFE);

        // Directed XLEN=32 divides
        run_op(32, 3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2", r);
        chk("div_m7_2_const", r, 32'hFFFF_FFFD);
        run_op(32, 3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2", r);
        chk("rem_m7_2_const", r, 32'hFFFF_FFFF);
        run_op(32, 3'd5, 32'd100, 32'd7, 0, "divu_100_7", r);
        chk("divu_100_7_const", r, 32'd14);
        run_op(32, 3'd7, 32'd100, 32'd7, 0, "remu_100_7", r);
        chk("remu_100_7_const", r, 32'd2);

        // Fast paths
        run_op(32, 3'd5, 32'd100, 32'd0, 0, "divu_by0", r);
        chk("divu_by0_const", r, 32'hFFFF_FFFF);
        run_op(32, 3'd6, 32'd100, 32'd0, 0, "rem_by0", r);
        chk("rem_by0_const", r, 32'h0000_0064);
        run_op(32, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf", r);
        chk("div_ovf_const", r, 32'h8000_0000);
        run_op(32, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf", r);
        chk("rem_ovf_const", r, 32'h0);

        // Give result a known nonzero value before the flush test
        run_op(32, 3'd5, 32'd1234, 32'd0, 0, "pre_flush", r);

        // Flush: DIVU, ignored start in cycle 5, kill in cycle 10
        @(posedge clk); #1;
        r0 = res32;
        start32 = 1; f32 = 3'd5; a32 = 32'd1000; b32 = 32'd7;
        @(posedge clk); #1;                          // cycle 1
        start32 = 0;
        repeat (4) begin @(posedge clk); #1; end     // cycle 5
        start32 = 1; f32 = 3'd0; a32 = $urandom; b32 = $urandom;
        @(posedge clk); #1;                          // cycle 6
        start32 = 0;
        repeat (4) begin @(posedge clk); #1; end     // cycle 10
        chk("flush_busy_c10", busy32, 1);
        kill32 = 1;
        @(posedge clk); #1;                          // cycle 11
        kill32 = 0;
        chk("flush_busy_c11", busy32, 0);
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy32 || done32) cnt++;
        end
        chk("flush_no_activity", cnt, 0);
        chk("flush_result_kept", res32, r0);
        run_op(32, 3'd0, 32'd3, 32'd5, 0, "mul_3_5", r);
        chk("mul_3_5_const", r, 32'd15);

        // kill and start together in IDLE: start dropped
        @(posedge clk); #1;
        start32 = 1; kill32 = 1; f32 = 3'd0; a32 = 32'd9; b32 = 32'd9;
        @(posedge clk); #1;
        start32 = 0; kill32 = 0;
        chk("kill_start_busy", busy32, 0);
        chk("kill_start_done", done32, 0);

        // Asynchronous reset mid-MULHU (cycle 20)
        @(posedge clk); #1;
        start32 = 1; f32 = 3'd3; a32 = $urandom; b32 = $urandom;
        @(posedge clk); #1;                          // cycle 1
        start32 = 0;
        repeat (19) begin @(posedge clk); #1; end    // cycle 20
        #2;
        rst = 1;
        #1;
        chk("rst_mid_busy", busy32, 0);
        chk("rst_mid_done", done32, 0);
        chk("rst_mid_result", res32, 0);
        rst = 0;
        run_op(32, 3'd4, 32'd20, 32'hFFFF_FFFD, 1, "div_20_m3", r);
        chk("div_20_m3_const", r, 32'hFFFF_FFFA);

        // XLEN=8: MULHSU then back-to-back REMU started in the FIN cycle
        run_op(8, 3'd2, 32'h80, 32'hFF, 0, "mulhsu8", r);
        chk("mulhsu8_const", r, 32'h80);
        run_op(8, 3'd7, 32'hFF, 32'h10, 1, "remu8_b2b", r);
        chk("remu8_b2b_const", r, 32'h0F);

        // Randomized ops, both widths, biased toward corner operands
        for (int w8 = 0; w8 < 2; w8++) begin
            mk = w8 ? 32'hFF : 32'hFFFF_FFFF;
            for (int i = 0; i < 30; i++) begin
                rf = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0: ra = w8 ? 32'h80 : 32'h8000_0000;
                    1: ra = mk;
                    default: ra = $urandom & mk;
                endcase
                case ($urandom_range(0, 6))
                    0: rb = 0;
                    1: rb = mk;
                    2: rb = 1;
                    default: rb = $urandom & mk;
                endcase
                run_op(w8 ? 8 : 32, rf, ra, rb, (i % 3) == 2, "rand", r);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
